mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Single-port word memory that answers the multi-cycle CPU's memory requests (instruction fetch and data load/store).
- The CPU side holds read_m or write_m together with address and write data until this block pulses ready.
- Access latency is fixed and set by parameter.
- Sits between the CPU datapath memory interface and the bench or top level. It is the responder end of the CPU's MemRead/MemWrite handshake.

Parameters:
- WORD_SIZE, 16, width of data words and address bus.
- ADDR_BITS, 8, number of address bits used to index storage; depth = 2^ADDR_BITS words.
- LATENCY, 2, cycles from request sample to ready pulse; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- read_m  input  1  read request level, held by CPU until ready.
- write_m  input  1  write request level, held by CPU until ready.
- address  input  WORD_SIZE  word address; only low ADDR_BITS used.
- data_in  input  WORD_SIZE  write data.
- data_out  output  WORD_SIZE  read data, registered; valid from the ready cycle onward.
- ready  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with ready, for an illegal request.

Behaviour:
- Reset (async, reset_n low): state = IDLE, counter = 0, data_out = 0, ready = 0, err = 0.
  - Storage contents are not cleared by reset.
- States: IDLE, BUSY, DONE. The 4-bit down-counter cnt is used only in BUSY.
- IDLE:
  - At a rising edge with read_m or write_m high: latch op, address[ADDR_BITS-1:0] and data_in; cnt <= LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Inputs are ignored; the latched values are used.
  - At each edge: if cnt != 0, decrement.
  - If cnt == 0, perform the access at this edge and go to DONE:
    - read: data_out <= mem[addr].
    - write: mem[addr] <= wdata; data_out unchanged.
- DONE:
  - ready = 1 (registered, one cycle); err = 1 if the latched request was illegal.
  - Next edge returns to IDLE unconditionally; requests are not sampled in DONE.
- Latency: ready is high in the cycle beginning LATENCY edges after the sampling edge.
  - LATENCY=1: sample at edge t, ready high after edge t+1, low after edge t+2.
- Back-to-back requests:
  - If the CPU still holds a request in the cycle after DONE, IDLE samples it as a new access.
  - Minimum request-to-request spacing is LATENCY+2 edges.
- Illegal request: read_m and write_m both high when sampled.
  - Follows the normal LATENCY timing to DONE.
  - No storage write; data_out unchanged; ready = 1 and err = 1 together.
- Address wrap: upper WORD_SIZE-ADDR_BITS address bits are ignored. With defaults, 16'h0105 aliases 16'h0005.
- Request dropped during BUSY: the access still completes and ready still pulses.
- Reset mid-operation: an access whose completing edge has not occurred is abandoned.
  - No storage write; state returns to IDLE; ready and err forced to 0.
- data_out holds its last read value across writes, idle cycles and illegal requests. Only reset or a completed read changes it.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then idle: reset_n low 2 cycles, then high; no requests for 5 cycles -> data_out=0, ready=0 and err=0 throughout.
- Write then read, LATENCY=2:
  - Write 16'hBEEF to 16'h0012 -> ready exactly 2 cycles after the sample edge, 1 cycle wide.
  - Then read 16'h0012 -> data_out=16'hBEEF in the ready cycle; ready never high 2 cycles in a row.
- Address alias: write 16'h1234 to 16'h0105, read 16'h0005 -> 16'h1234.
  - A following read of 16'h0006 returns that location's contents, not 16'h1234.
- Illegal request: read_m=write_m=1, address 16'h0012 -> ready=1 and err=1 in the same cycle.
  - A following read of 16'h0012 returns 16'hBEEF; data_out unchanged during the illegal access.
- Reset mid-write: start a write of 16'hAAAA to 16'h0020 (location previously 16'h5555), assert reset_n low 1 cycle after sampling -> ready never pulses, state is IDLE.
  - A subsequent read of 16'h0020 returns 16'h5555.
- Held request and latency sweep, LATENCY=1 and 4: hold read_m high continuously -> ready pulses every LATENCY+2 cycles, each pulse 1 cycle wide.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency single-port word memory answering CPU read/write requests.
// Ports: clk, reset_n, read_m, write_m, address, data_in -> data_out, ready, err.
module mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 read_m,
  input  logic                 write_m,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 ready,
  output logic                 err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic take, fire;
  logic rd_q, wr_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic illegal, do_read, do_write;

  if (ADDR_BITS < WORD_SIZE) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^address[WORD_SIZE-1:ADDR_BITS];
  end

  assign illegal  = rd_q & wr_q;
  assign do_read  = fire & rd_q & ~wr_q;
  assign do_write = fire & wr_q & ~rd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_m || write_m) begin
          take    = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          fire    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= fire;
      err     <= fire & illegal;
      if (take) begin
        rd_q    <= read_m;
        wr_q    <= write_m;
        addr_q  <= address[ADDR_BITS-1:0];
        wdata_q <= data_in;
      end
      if (do_read) begin
        data_out <= mem[addr_q];
      end
    end
  end

  // Storage has no reset; an abandoned access never fires
  // because reset forces the state back to IDLE.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: random requests vs a word-array model.
// Side instances with LATENCY 1 and 4 check held-request pulse spacing.
module tb_mem_responder;

  localparam int LAT   = 2;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rst_s = 1'b0;
  logic read_m = 1'b0;
  logic write_m = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic ready, err;

  logic [15:0] dout_unused_a, dout_unused_b;
  logic rdy_a, rdy_b, err_a, err_b;

  always #5 clk = ~clk;

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n), .read_m(read_m), .write_m(write_m),
    .address(address), .data_in(data_in), .data_out(data_out),
    .ready(ready), .err(err)
  );

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(LAT_A)) u_la (
    .clk(clk), .reset_n(rst_s), .read_m(1'b1), .write_m(1'b0),
    .address(16'h0033), .data_in(16'h0000), .data_out(dout_unused_a),
    .ready(rdy_a), .err(err_a)
  );

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(LAT_B)) u_lb (
    .clk(clk), .reset_n(rst_s), .read_m(1'b1), .write_m(1'b0),
    .address(16'h0044), .data_in(16'h0000), .data_out(dout_unused_b),
    .ready(rdy_b), .err(err_b)
  );

  typedef struct {
    logic        is_rd;
    logic        err;
    logic [15:0] data;
    int          t;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [15:0] model [256];
  logic [7:0]  wl[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Main monitor: pops expectations when ready shows up.
  logic [15:0] exp_dout = '0;
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    exp_t it;
    if (!reset_n) begin
      exp_dout   = '0;
      prev_ready = 1'b0;
    end else begin
      if (ready) begin
        if (q.size() == 0) begin
          chk("unexpected_ready", 32'(ready), 32'd0);
        end else begin
          it = q.pop_front();
          chk("latency", 32'(cyc - it.t), 32'(LAT));
          chk("err", 32'(err), 32'(it.err));
          if (it.is_rd) exp_dout = it.data;
        end
        chk("ready_width", 32'(prev_ready), 32'd0);
      end else begin
        chk("err_without_ready", 32'(err), 32'd0);
      end
      chk("data_out", 32'(data_out), 32'(exp_dout));
      prev_ready = ready;
    end
  end

  // Held-read monitors for the LATENCY 1 and 4 instances.
  int last_a = -1, last_b = -1, n_a = 0, n_b = 0;
  always @(negedge clk) begin
    if (rst_s) begin
      if (rdy_a) begin
        if (last_a >= 0) chk("spacing_l1", 32'(cyc - last_a), 32'(LAT_A + 2));
        chk("err_l1", 32'(err_a), 32'd0);
        last_a = cyc;
        n_a++;
      end
      if (rdy_b) begin
        if (last_b >= 0) chk("spacing_l4", 32'(cyc - last_b), 32'(LAT_B + 2));
        chk("err_l4", 32'(err_b), 32'd0);
        last_b = cyc;
        n_b++;
      end
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input logic hold);
    exp_t it;
    int n;
    @(negedge clk);
    read_m  = rd;
    write_m = wr;
    address = a;
    data_in = d;
    it.is_rd = rd & ~wr;
    it.err   = rd & wr;
    it.data  = model[a[7:0]];
    it.t     = cyc + 1;
    if (wr && !rd) begin
      model[a[7:0]] = d;
      wl.push_back(a[7:0]);
    end
    q.push_back(it);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!hold) begin
        read_m  = 1'b0;
        write_m = 1'b0;
        address = 16'($urandom);
        data_in = 16'($urandom);
      end
    end while (!ready && n < 20);
    if (!ready) begin
      chk("ready_timeout", 32'(ready), 32'd1);
      void'(q.pop_front());
    end
    read_m  = 1'b0;
    write_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    logic [7:0] lo;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    rst_s   = 1'b1;
    repeat (5) @(negedge clk);

    req(1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b1);
    req(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1);
    req(1'b0, 1'b1, 16'h0006, 16'h6666, 1'b1);
    req(1'b0, 1'b1, 16'h0105, 16'h1234, 1'b1);
    req(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1);
    req(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b1);
    req(1'b1, 1'b1, 16'h0012, 16'h9999, 1'b1);
    req(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1);
    req(1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0);

    @(negedge clk);
    write_m = 1'b1;
    address = 16'h0020;
    data_in = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    write_m = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        lo = wl[$urandom_range(0, wl.size() - 1)];
        req(1'b1, 1'b1, {8'($urandom), lo}, 16'($urandom), 1'($urandom));
      end else if (r < 5) begin
        lo = 8'($urandom);
        req(1'b0, 1'b1, {8'($urandom), lo}, 16'($urandom), 1'($urandom));
      end else begin
        lo = wl[$urandom_range(0, wl.size() - 1)];
        req(1'b1, 1'b0, {8'($urandom), lo}, 16'($urandom), 1'($urandom));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("pulses_l1", 32'(n_a >= 3), 32'd1);
    chk("pulses_l4", 32'(n_b >= 3), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
